// File: rtl/loader_run_sequencer.sv
// -----------------------------------------------------------------------------
// loader_run_sequencer
//
// Run sequencer for the 16-node mesh cosimulation harness. One command port
// fills the per-node master-loader FIFOs. The final command of a batch
// triggers a common start pulse. The block then waits until every loader is
// idle, or until an optional cycle limit expires. Finally it scans the PMU
// counters of every node in node-major order and streams each word out over a
// valid/ready result port.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o  command handshake (ready only while loading)
//   cmd_node_i               target node of the command
//   cmd_id_i/cmd_write_i/
//   cmd_axlen_i              transaction fields forwarded to the loader
//   cmd_last_i               final command of the batch; starts the run
//   depth_i                  request depth, latched with the final command
//   timeout_i                run-cycle limit, 0 disables the limit
//   id_o/write_o/axlen_o     per-node loader command fields (held)
//   fifo_push_o              per-node one-cycle loader FIFO push strobes
//   start_o                  common start pulse
//   req_depth_o              latched request depth
//   idle_i                   per-node loader idle flags
//   pmu_addr_o               PMU read address, identical on every node
//   pmu_data_i               per-node PMU read data
//   res_valid_o/res_ready_i  result handshake
//   res_node_o/res_addr_o/
//   res_data_o/res_last_o    result word; last marks the final word of a run
//   busy_o                   high whenever the sequencer is not loading
//   timeout_o                sticky flag: the last run hit the cycle limit
// -----------------------------------------------------------------------------
module loader_run_sequencer #(
    parameter int N_NODES    = 16,
    parameter int NODE_W     = $clog2(N_NODES),
    parameter int PMU_ADDR_W = 5,
    parameter int N_PMU_REGS = 8,
    parameter int TIMEOUT_W  = 20
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [NODE_W-1:0]     cmd_node_i,
    input  logic [4:0]            cmd_id_i,
    input  logic                  cmd_write_i,
    input  logic [7:0]            cmd_axlen_i,
    input  logic                  cmd_last_i,
    input  logic [7:0]            depth_i,
    input  logic [TIMEOUT_W-1:0]  timeout_i,

    output logic [4:0]            id_o        [N_NODES],
    output logic                  write_o     [N_NODES],
    output logic [7:0]            axlen_o     [N_NODES],
    output logic                  fifo_push_o [N_NODES],
    output logic                  start_o,
    output logic [7:0]            req_depth_o,
    input  logic                  idle_i      [N_NODES],

    output logic [PMU_ADDR_W-1:0] pmu_addr_o  [N_NODES],
    input  logic [63:0]           pmu_data_i  [N_NODES],

    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [NODE_W-1:0]     res_node_o,
    output logic [PMU_ADDR_W-1:0] res_addr_o,
    output logic [63:0]           res_data_o,
    output logic                  res_last_o,

    output logic                  busy_o,
    output logic                  timeout_o
);

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_SET   = 3'd3,
        ST_CAP   = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    // The node field can encode more values than there are nodes when
    // N_NODES is not a power of two; this mask marks the encodings that exist.
    localparam int NODE_SPACE = 1 << NODE_W;
    localparam logic [NODE_SPACE-1:0] NODE_OK_MASK =
        {NODE_SPACE{1'b1}} >> (NODE_SPACE - N_NODES);

    localparam logic [NODE_W-1:0]     LAST_NODE = NODE_W'(N_NODES - 1);
    localparam logic [PMU_ADDR_W-1:0] LAST_ADDR = PMU_ADDR_W'(N_PMU_REGS - 1);
    localparam logic [TIMEOUT_W-1:0]  TIMER_MAX = {TIMEOUT_W{1'b1}};
    // Idle flags lag the start pulse; they are trusted only from this count.
    localparam logic [TIMEOUT_W-1:0]  IDLE_MIN  = TIMEOUT_W'(2);

    state_t                state_q,     state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic [4:0]            id_q    [N_NODES];
    logic [4:0]            id_d    [N_NODES];
    logic                  write_q [N_NODES];
    logic                  write_d [N_NODES];
    logic [7:0]            axlen_q [N_NODES];
    logic [7:0]            axlen_d [N_NODES];
    logic [N_NODES-1:0]    push_q,      push_d;
    logic                  start_q,     start_d;
    logic [7:0]            depth_q,     depth_d;
    logic [PMU_ADDR_W-1:0] pmu_addr_q,  pmu_addr_d;
    logic [TIMEOUT_W-1:0]  timer_q,     timer_d;
    logic [NODE_W-1:0]     node_q,      node_d;
    logic [PMU_ADDR_W-1:0] addr_q,      addr_d;
    logic                  res_valid_q, res_valid_d;
    logic [NODE_W-1:0]     res_node_q,  res_node_d;
    logic [PMU_ADDR_W-1:0] res_addr_q,  res_addr_d;
    logic [63:0]           res_data_q,  res_data_d;
    logic                  res_last_q,  res_last_d;
    logic                  busy_q,      busy_d;
    logic                  timeout_q,   timeout_d;

    logic                  cmd_hs_s;
    logic                  node_ok_s;
    logic                  all_idle_s;
    logic [TIMEOUT_W-1:0]  timer_inc_s;

    // Handshake qualification, node range check and saturating run timer.
    always_comb begin
        cmd_hs_s    = cmd_valid_i && cmd_ready_q;
        node_ok_s   = NODE_OK_MASK[cmd_node_i];
        // The timer sticks at all-ones so a long unlimited run never wraps
        // back into a small count that could match timeout_i again.
        if (timer_q == TIMER_MAX) begin
            timer_inc_s = timer_q;
        end else begin
            timer_inc_s = timer_q + TIMEOUT_W'(1);
        end
    end

    // AND-reduce the loader idle flags.
    always_comb begin
        all_idle_s = 1'b1;
        for (int n = 0; n < N_NODES; n++) begin
            all_idle_s = all_idle_s & idle_i[n];
        end
    end

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        write_d     = write_q;
        axlen_d     = axlen_q;
        push_d      = {N_NODES{1'b0}};
        start_d     = 1'b0;
        depth_d     = depth_q;
        pmu_addr_d  = pmu_addr_q;
        timer_d     = timer_q;
        node_d      = node_q;
        addr_d      = addr_q;
        res_valid_d = res_valid_q;
        res_node_d  = res_node_q;
        res_addr_d  = res_addr_q;
        res_data_d  = res_data_q;
        res_last_d  = res_last_q;
        timeout_d   = timeout_q;

        case (state_q)
            ST_LOAD: begin
                if (cmd_hs_s) begin
                    // Out-of-range nodes are accepted but produce no push.
                    for (int n = 0; n < N_NODES; n++) begin
                        if (node_ok_s && (cmd_node_i == NODE_W'(n))) begin
                            push_d[n]  = 1'b1;
                            id_d[n]    = cmd_id_i;
                            write_d[n] = cmd_write_i;
                            axlen_d[n] = cmd_axlen_i;
                        end else begin
                            push_d[n]  = 1'b0;
                        end
                    end
                    if (cmd_last_i) begin
                        // Start lands in the same cycle as the final push.
                        depth_d   = depth_i;
                        timeout_d = 1'b0;
                        start_d   = 1'b1;
                        state_d   = ST_START;
                    end else begin
                        state_d   = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end

            ST_START: begin
                timer_d = {TIMEOUT_W{1'b0}};
                state_d = ST_RUN;
            end

            ST_RUN: begin
                // Decisions use the count including the current cycle, so the
                // shortest run is two RUN cycles.
                timer_d = timer_inc_s;
                if ((timer_inc_s >= IDLE_MIN) && all_idle_s) begin
                    node_d  = {NODE_W{1'b0}};
                    addr_d  = {PMU_ADDR_W{1'b0}};
                    state_d = ST_SET;
                end else if ((timeout_i != {TIMEOUT_W{1'b0}}) &&
                             (timer_inc_s == timeout_i)) begin
                    timeout_d = 1'b1;
                    node_d    = {NODE_W{1'b0}};
                    addr_d    = {PMU_ADDR_W{1'b0}};
                    state_d   = ST_SET;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_SET: begin
                pmu_addr_d = addr_q;
                state_d    = ST_CAP;
            end

            ST_CAP: begin
                // pmu_addr_o has been stable for one full cycle here.
                res_data_d  = pmu_data_i[node_q];
                res_node_d  = node_q;
                res_addr_d  = addr_q;
                res_last_d  = (node_q == LAST_NODE) && (addr_q == LAST_ADDR);
                res_valid_d = 1'b1;
                state_d     = ST_OUT;
            end

            ST_OUT: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    if (res_last_q) begin
                        state_d = ST_LOAD;
                    end else begin
                        if (addr_q == LAST_ADDR) begin
                            addr_d = {PMU_ADDR_W{1'b0}};
                            node_d = node_q + NODE_W'(1);
                        end else begin
                            addr_d = addr_q + PMU_ADDR_W'(1);
                        end
                        state_d = ST_SET;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase

        busy_d      = (state_d != ST_LOAD);
        cmd_ready_d = (state_d == ST_LOAD);
    end

    // State and output registers; reset returns to an idle LOAD state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_LOAD;
            cmd_ready_q <= 1'b0;
            for (int n = 0; n < N_NODES; n++) begin
                id_q[n]    <= 5'd0;
                write_q[n] <= 1'b0;
                axlen_q[n] <= 8'd0;
            end
            push_q      <= {N_NODES{1'b0}};
            start_q     <= 1'b0;
            depth_q     <= 8'd0;
            pmu_addr_q  <= {PMU_ADDR_W{1'b0}};
            timer_q     <= {TIMEOUT_W{1'b0}};
            node_q      <= {NODE_W{1'b0}};
            addr_q      <= {PMU_ADDR_W{1'b0}};
            res_valid_q <= 1'b0;
            res_node_q  <= {NODE_W{1'b0}};
            res_addr_q  <= {PMU_ADDR_W{1'b0}};
            res_data_q  <= 64'd0;
            res_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            id_q        <= id_d;
            write_q     <= write_d;
            axlen_q     <= axlen_d;
            push_q      <= push_d;
            start_q     <= start_d;
            depth_q     <= depth_d;
            pmu_addr_q  <= pmu_addr_d;
            timer_q     <= timer_d;
            node_q      <= node_d;
            addr_q      <= addr_d;
            res_valid_q <= res_valid_d;
            res_node_q  <= res_node_d;
            res_addr_q  <= res_addr_d;
            res_data_q  <= res_data_d;
            res_last_q  <= res_last_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    // Fan the registered per-node state out to the array ports.
    always_comb begin
        for (int n = 0; n < N_NODES; n++) begin
            id_o[n]        = id_q[n];
            write_o[n]     = write_q[n];
            axlen_o[n]     = axlen_q[n];
            fifo_push_o[n] = push_q[n];
            pmu_addr_o[n]  = pmu_addr_q;
        end
    end

    // Scalar outputs come straight from their registers.
    always_comb begin
        cmd_ready_o = cmd_ready_q;
        start_o     = start_q;
        req_depth_o = depth_q;
        res_valid_o = res_valid_q;
        res_node_o  = res_node_q;
        res_addr_o  = res_addr_q;
        res_data_o  = res_data_q;
        res_last_o  = res_last_q;
        busy_o      = busy_q;
        timeout_o   = timeout_q;
    end

endmodule

// File: tb/tb_loader_run_sequencer.sv
// -----------------------------------------------------------------------------
// tb_loader_run_sequencer
//
// Directed-random bench for loader_run_sequencer. Command batches and idle
// patterns are randomised. Expected pushes, run length, timeout flag and the
// node-major result stream come from a plain behavioural model of the rules.
// -----------------------------------------------------------------------------
module tb_loader_run_sequencer;

    localparam int N      = 16;
    localparam int NW     = 4;
    localparam int AW     = 5;
    localparam int NR     = 8;
    localparam int TW     = 20;
    localparam int NWORDS = N * NR;

    logic          aclk;
    logic          aresetn;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [NW-1:0] cmd_node_i;
    logic [4:0]    cmd_id_i;
    logic          cmd_write_i;
    logic [7:0]    cmd_axlen_i;
    logic          cmd_last_i;
    logic [7:0]    depth_i;
    logic [TW-1:0] timeout_i;
    logic [4:0]    id_o        [N];
    logic          write_o     [N];
    logic [7:0]    axlen_o     [N];
    logic          fifo_push_o [N];
    logic          start_o;
    logic [7:0]    req_depth_o;
    logic          idle_i      [N];
    logic [AW-1:0] pmu_addr_o  [N];
    logic [63:0]   pmu_data_i  [N];
    logic          res_valid_o;
    logic          res_ready_i;
    logic [NW-1:0] res_node_o;
    logic [AW-1:0] res_addr_o;
    logic [63:0]   res_data_o;
    logic          res_last_o;
    logic          busy_o;
    logic          timeout_o;

    loader_run_sequencer #(
        .N_NODES(N), .NODE_W(NW), .PMU_ADDR_W(AW), .N_PMU_REGS(NR), .TIMEOUT_W(TW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_node_i(cmd_node_i), .cmd_id_i(cmd_id_i), .cmd_write_i(cmd_write_i),
        .cmd_axlen_i(cmd_axlen_i), .cmd_last_i(cmd_last_i),
        .depth_i(depth_i), .timeout_i(timeout_i),
        .id_o(id_o), .write_o(write_o), .axlen_o(axlen_o), .fifo_push_o(fifo_push_o),
        .start_o(start_o), .req_depth_o(req_depth_o), .idle_i(idle_i),
        .pmu_addr_o(pmu_addr_o), .pmu_data_i(pmu_data_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_node_o(res_node_o), .res_addr_o(res_addr_o), .res_data_o(res_data_o),
        .res_last_o(res_last_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         node;
        logic [4:0] id;
        logic       wr;
        logic [7:0] len;
    } cmd_t;

    cmd_t          batch[$];
    logic [31:0]   salt;
    int            idle_from;
    int            stuck_node;
    logic [TW-1:0] tmo;
    logic          exp_to;
    logic [4:0]    exp_id  [N];
    logic          exp_wr  [N];
    logic [7:0]    exp_len [N];

    // PMU model word for a node/address pair; the per-run salt exposes stale data.
    function automatic logic [63:0] pmu_word(input logic [31:0] s, input int node, input int addr);
        return {s, 8'(node), 8'h5A, 16'(addr)};
    endfunction

    // Combinational PMU model: each node answers for its own current address.
    always_comb begin
        for (int n = 0; n < N; n++) begin
            pmu_data_i[n] = pmu_word(salt, n, int'(pmu_addr_o[n]));
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic clear_model();
        for (int n = 0; n < N; n++) begin
            exp_id[n]  = 5'd0;
            exp_wr[n]  = 1'b0;
            exp_len[n] = 8'd0;
        end
        exp_to = 1'b0;
    endtask

    // Idle pattern for RUN cycle k: all idle from idle_from on, else at least one busy.
    task automatic drive_idle(input int k);
        for (int n = 0; n < N; n++) idle_i[n] = 1'b1;
        if (k < idle_from) begin
            for (int n = 0; n < N; n++) begin
                if ($urandom_range(0, 3) == 0) idle_i[n] = 1'b0;
            end
            if (stuck_node >= 0) idle_i[stuck_node] = 1'b0;
            else idle_i[$urandom_range(0, N - 1)] = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        int bad;
        bad = 0;
        for (int n = 0; n < N; n++) begin
            if (fifo_push_o[n] !== 1'b0 || id_o[n] !== 5'd0 || write_o[n] !== 1'b0 ||
                axlen_o[n] !== 8'd0 || pmu_addr_o[n] !== 5'd0) bad++;
        end
        chk({tag, "_node_outs"}, 64'(bad), 64'd0);
        chk({tag, "_start"}, start_o, 1'b0);
        chk({tag, "_depth"}, req_depth_o, 8'd0);
        chk({tag, "_res"}, {res_valid_o, res_last_o, res_node_o, res_addr_o}, 64'd0);
        chk({tag, "_res_data"}, res_data_o, 64'd0);
        chk({tag, "_busy_to"}, {busy_o, timeout_o}, 64'd0);
    endtask

    task automatic make_batch(input int n);
        cmd_t c;
        batch.delete();
        for (int i = 0; i < n; i++) begin
            c.node = $urandom_range(0, N - 1);
            c.id   = 5'($urandom);
            c.wr   = 1'($urandom);
            c.len  = 8'($urandom);
            batch.push_back(c);
        end
    endtask

    task automatic do_batch(input logic [7:0] depth);
        int   waitc;
        int   bad;
        logic last;
        logic [N-1:0] pv_obs;
        logic [N-1:0] pv_exp;
        waitc = 0;
        while (cmd_ready_o !== 1'b1 && waitc < 20) begin
            step();
            waitc++;
        end
        chk("cmd_ready_wait", cmd_ready_o, 1'b1);
        timeout_i = tmo;
        for (int i = 0; i < batch.size(); i++) begin
            last        = (i == batch.size() - 1);
            cmd_valid_i = 1'b1;
            cmd_node_i  = NW'(batch[i].node);
            cmd_id_i    = batch[i].id;
            cmd_write_i = batch[i].wr;
            cmd_axlen_i = batch[i].len;
            cmd_last_i  = last;
            depth_i     = last ? depth : 8'($urandom);
            for (int n = 0; n < N; n++) idle_i[n] = 1'($urandom);
            step();
            exp_id[batch[i].node]  = batch[i].id;
            exp_wr[batch[i].node]  = batch[i].wr;
            exp_len[batch[i].node] = batch[i].len;
            pv_exp = '0;
            pv_exp[batch[i].node] = 1'b1;
            bad = 0;
            for (int n = 0; n < N; n++) begin
                pv_obs[n] = fifo_push_o[n];
                if (id_o[n] !== exp_id[n] || write_o[n] !== exp_wr[n] ||
                    axlen_o[n] !== exp_len[n]) bad++;
            end
            chk("push_vec", pv_obs, pv_exp);
            chk("push_fields", {id_o[batch[i].node], write_o[batch[i].node], axlen_o[batch[i].node]},
                {batch[i].id, batch[i].wr, batch[i].len});
            chk("held_fields", 64'(bad), 64'd0);
            chk("start_pulse", start_o, last);
            if (last) begin
                exp_to = 1'b0;
                chk("req_depth", req_depth_o, depth);
                chk("busy_start", busy_o, 1'b1);
                chk("cmd_ready_start", cmd_ready_o, 1'b0);
            end else begin
                chk("busy_load", busy_o, 1'b0);
            end
            chk("timeout_sticky", timeout_o, exp_to);
        end
        cmd_valid_i = 1'b0;
        cmd_last_i  = 1'b0;
    endtask

    task automatic do_run();
        int L;
        int found;
        logic [N-1:0] pv_obs;
        L = -1;
        for (int k = 1; k <= 200000 && L < 0; k++) begin
            if ((k >= 2 && k >= idle_from) || (tmo != 0 && k == int'(tmo))) L = k;
        end
        exp_to = (tmo != 0 && L == int'(tmo)) && !(L >= 2 && L >= idle_from);
        found = -1;
        for (int c = 1; c <= L + 10; c++) begin
            step();
            if (c == 1) begin
                for (int n = 0; n < N; n++) pv_obs[n] = fifo_push_o[n];
                chk("run_no_push", pv_obs, 0);
                chk("run_no_start", start_o, 1'b0);
                chk("run_busy", busy_o, 1'b1);
            end
            if (res_valid_o === 1'b1) begin
                found = c;
                break;
            end
            drive_idle(c);
        end
        chk("run_len", 64'(found), 64'(L + 3));
        chk("timeout_flag", timeout_o, exp_to);
    endtask

    task automatic do_scan(input int max_words);
        int waitc;
        int stalls;
        int bad;
        int en;
        int ea;
        logic r;
        for (int w = 0; w < max_words; w++) begin
            en = w / NR;
            ea = w % NR;
            waitc = 0;
            while (res_valid_o !== 1'b1 && waitc < 12) begin
                step();
                waitc++;
            end
            chk("res_valid_wait", res_valid_o, 1'b1);
            if (res_valid_o !== 1'b1) return;
            r = 1'b0;
            stalls = 0;
            while (!r) begin
                bad = 0;
                for (int n = 0; n < N; n++) if (pmu_addr_o[n] !== AW'(ea)) bad++;
                chk("pmu_addr", 64'(bad), 64'd0);
                chk("res_node", res_node_o, 64'(en));
                chk("res_addr", res_addr_o, 64'(ea));
                chk("res_data", res_data_o, pmu_word(salt, en, ea));
                chk("res_last", res_last_o, (w == NWORDS - 1));
                chk("res_valid_hold", res_valid_o, 1'b1);
                r = (stalls >= 6) ? 1'b1 : ($urandom_range(0, 1) == 1);
                res_ready_i = r;
                stalls++;
                step();
            end
            res_ready_i = 1'b0;
            chk("res_valid_drop", res_valid_o, 1'b0);
            if (w == NWORDS - 1) begin
                chk("busy_end", busy_o, 1'b0);
                chk("cmd_ready_end", cmd_ready_o, 1'b1);
                chk("timeout_end", timeout_o, exp_to);
            end
        end
        if (max_words < NWORDS) begin
            waitc = 0;
            while (res_valid_o !== 1'b1 && waitc < 12) begin
                step();
                waitc++;
            end
            chk("res_valid_abort", res_valid_o, 1'b1);
        end
    endtask

    task automatic reset_now(input string tag);
        aresetn = 1'b0;
        #1;
        check_zero({tag, "_imm"});
        cmd_valid_i = 1'b0;
        cmd_last_i  = 1'b0;
        res_ready_i = 1'b0;
        step();
        step();
        check_zero({tag, "_held"});
        aresetn = 1'b1;
        clear_model();
        step();
        chk({tag, "_ready"}, cmd_ready_o, 1'b1);
    endtask

    // Absolute time limit so the bench always terminates.
    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_t c;
        aresetn     = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_node_i  = '0;
        cmd_id_i    = '0;
        cmd_write_i = 1'b0;
        cmd_axlen_i = '0;
        cmd_last_i  = 1'b0;
        depth_i     = '0;
        timeout_i   = '0;
        res_ready_i = 1'b0;
        for (int n = 0; n < N; n++) idle_i[n] = 1'b0;
        salt       = $urandom;
        idle_from  = 0;
        stuck_node = -1;
        tmo        = '0;
        clear_model();

        // Power-on reset.
        repeat (3) @(negedge aclk);
        check_zero("por");
        aresetn = 1'b1;
        step();
        chk("por_ready", cmd_ready_o, 1'b1);
        chk("por_busy", busy_o, 1'b0);

        // Nodes 2, 5, 2; idle throughout; minimum two-cycle run.
        batch.delete();
        c.node = 2; c.id = 5'($urandom); c.wr = 1'($urandom); c.len = 8'($urandom); batch.push_back(c);
        c.node = 5; c.id = 5'($urandom); c.wr = 1'($urandom); c.len = 8'($urandom); batch.push_back(c);
        c.node = 2; c.id = 5'd3; c.wr = 1'b1; c.len = 8'd4; batch.push_back(c);
        idle_from = 0; stuck_node = -1; tmo = '0; salt = $urandom;
        do_batch(8'($urandom));
        do_run();
        do_scan(NWORDS);

        // Node 7 never idle: ten-cycle timeout, scan still completes.
        make_batch($urandom_range(1, 6));
        idle_from = 1 << 30; stuck_node = 7; tmo = TW'(10); salt = $urandom;
        do_batch(8'($urandom));
        do_run();
        do_scan(NWORDS);

        // Idle and timeout in the same cycle: idle wins, flag is cleared.
        make_batch(3);
        tmo = TW'($urandom_range(3, 12)); idle_from = int'(tmo); stuck_node = -1; salt = $urandom;
        do_batch(8'($urandom));
        do_run();
        do_scan(NWORDS);

        // No limit: idle held low for 5000 cycles keeps the run going.
        make_batch(2);
        tmo = '0; idle_from = 5001; salt = $urandom;
        do_batch(8'($urandom));
        do_run();
        do_scan(NWORDS);

        // Reset in the middle of a run.
        make_batch($urandom_range(1, 4));
        tmo = '0; idle_from = 1 << 30;
        do_batch(8'($urandom));
        for (int k = 1; k <= 4; k++) begin
            step();
            drive_idle(k);
        end
        reset_now("rst_run");

        // Limit of one cycle fires before idle is ever considered.
        make_batch($urandom_range(1, 5));
        tmo = TW'(1); idle_from = 0; salt = $urandom;
        do_batch(8'($urandom));
        do_run();
        do_scan(NWORDS);

        // Reset while a result word is pending.
        make_batch($urandom_range(1, 5));
        tmo = '0; idle_from = $urandom_range(0, 6); salt = $urandom;
        do_batch(8'($urandom));
        do_run();
        do_scan(5);
        reset_now("rst_out");

        // Fresh batch after reset runs normally.
        make_batch($urandom_range(1, 6));
        tmo = TW'($urandom_range(20, 40)); idle_from = $urandom_range(2, 10); salt = $urandom;
        do_batch(8'($urandom));
        do_run();
        do_scan(NWORDS);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/loader_run_sequencer.md
# loader_run_sequencer

Run sequencer for the 16-node mesh cosimulation harness. It accepts a batch of per-node transaction commands and pushes each into the addressed node's master-loader FIFO. It then fires the common start pulse and waits until every loader reports idle, or a timeout expires. Finally it scans each node's PMU counters and streams them out as a valid/ready result stream, so a testbench or host needs only one command port and one result port.

## Interface
Parameters:
- N_NODES, 16, number of loader/PMU pairs
- NODE_W, $clog2(N_NODES), node index width
- PMU_ADDR_W, 5, PMU register address width
- N_PMU_REGS, 8, PMU addresses scanned per node (0..N_PMU_REGS-1)
- TIMEOUT_W, 20, run-timeout counter width

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake
- cmd_node_i  in  NODE_W  target node
- cmd_id_i  in  5, cmd_write_i  in  1, cmd_axlen_i  in  8  transaction fields
- cmd_last_i  in  1  final command of batch; starts the run
- depth_i  in  8  request depth; latched on the cmd_last handshake
- timeout_i  in  TIMEOUT_W  run-cycle limit; 0 = no limit
- id_o[N_NODES]  out  5, write_o[N_NODES]  out  1, axlen_o[N_NODES]  out  8  loader command fields
- fifo_push_o[N_NODES]  out  1  loader FIFO push strobes
- start_o  out  1  common start pulse
- req_depth_o  out  8  latched depth
- idle_i[N_NODES]  in  1  loader idle flags
- pmu_addr_o[N_NODES]  out  PMU_ADDR_W  PMU read address (same value on all nodes)
- pmu_data_i[N_NODES]  in  64  PMU read data
- res_valid_o / res_ready_i  out/in  1  result handshake
- res_node_o  out  NODE_W, res_addr_o  out  PMU_ADDR_W, res_data_o  out  64, res_last_o  out  1  result word
- busy_o  out  1  high in any state except LOAD
- timeout_o  out  1  sticky: last run timed out

## Operation
- States: LOAD, START, RUN, SET, CAP, OUT.
- LOAD:
  - cmd_ready_o=1.
  - On handshake with cmd_node_i<N_NODES: the next cycle, id_o/write_o/axlen_o[node] take the fields (held until that node's next push) and fifo_push_o[node]=1 for exactly one cycle.
  - cmd_node_i>=N_NODES: command is accepted and dropped.
  - Handshake with cmd_last_i=1: the push still occurs, depth_i is latched, timeout_o is cleared, next state START.
- START: start_o=1 for one cycle, timer cleared → RUN.
- RUN:
  - Timer increments every cycle.
  - Idle is evaluated only once the timer is >=2, to cover loader idle lag.
  - All idle_i=1 → SET with node=0, addr=0.
  - timeout_i!=0 and timer==timeout_i → timeout_o=1, → SET.
  - Idle and timeout in the same cycle: idle wins, timeout_o stays 0.
- SET: pmu_addr_o[all]=addr → CAP.
- CAP: res_data_o←pmu_data_i[node]; res_node_o, res_addr_o and res_last_o (node==N_NODES-1 and addr==N_PMU_REGS-1) registered → OUT.
- OUT:
  - res_valid_o=1. All res_* outputs stay stable until res_ready_i.
  - On handshake: if last → LOAD. Otherwise addr+1; when addr wraps from N_PMU_REGS-1 to 0, node+1. Then → SET.
- Scan order is node-major: (0,0),(0,1)…(N_NODES-1,N_PMU_REGS-1). Total N_NODES*N_PMU_REGS words per run.
- Timer saturates at all-ones and does not wrap. With timeout_i=0 the run waits indefinitely.

## Timing
- Reset: state LOAD.
  - All of the following are 0: fifo_push_o, start_o, id_o, write_o, axlen_o, req_depth_o, pmu_addr_o, res_*, busy_o, timeout_o.
  - cmd_ready_o=1 once reset deasserts.
- Reset mid-run: immediate return to LOAD. No stray push or start is emitted; a pending result is dropped.
- Push latency: 1 cycle after handshake. Back-to-back commands give one push per cycle.
- start_o: the cycle after the cmd_last handshake, i.e. the same cycle as the final push. Loaders must accept a push and start in the same cycle.
- Minimum run: start_o at cycle t; earliest SET at t+3.
- Per result word: SET → CAP → OUT, at least 3 cycles. Data is sampled exactly one cycle after pmu_addr_o changes.
- pmu_addr_o holds its last value outside SET/CAP/OUT.

## Test plan
- Reset, then 3 commands with cmd_last on the 3rd, to nodes 2, 5, 2 (id 3, write 1, axlen 4 on the last) → pushes on nodes 2, 5, 2 on consecutive cycles. id_o[2]=3, axlen_o[2]=4. start_o coincides with the 3rd push. req_depth_o=depth_i.
- idle_i all 1 throughout → RUN lasts exactly 2 cycles. Then 128 result words in node-major order, res_last_o only on (15,7). busy_o drops the cycle after the last handshake.
- PMU model returning {node,addr} pattern, res_ready_i toggling randomly → every word matches its pattern, and res_* stay stable while res_valid_o=1 and res_ready_i=0.
- timeout_i=10, idle_i[7] stuck 0 → timeout_o=1 after 10 RUN cycles and the scan still completes. The next batch clears timeout_o.
- idle and timeout asserted in the same cycle → timeout_o=0. timeout_i=0 with idle held low for 5000 cycles → remains in RUN.
- aresetn asserted during RUN and again during OUT → all outputs 0 immediately. A fresh batch afterwards runs normally.
